// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types and constants (optional UART_TX_PARITY_EN)
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int STOP_BITS            = 1;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// uart_baud_cnt : bit-period counter, tick on the last cycle of each period
// Rev 1.0
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at the last count; only clr restarts a period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != C_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = (cnt_q == C_LAST);
  assign pre_tick = (cnt_q == C_PRE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_tx_ctrl : FIFO-fed 8N1 UART transmitter (even parity with UART_TX_PARITY_EN)
// Rev 1.0
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int RD_LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [UART_DATA_W-1:0] fifo_data,
  output logic                   fifo_rd_en,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done
);

  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam int LAT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(UART_DATA_W - 1);
  localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(RD_LATENCY);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if (RD_LATENCY < 1) begin : g_bad_rd_latency
    $error("uart_tx_ctrl: RD_LATENCY must be >= 1");
  end
  if (STOP_BITS != 1) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: only one stop bit is supported");
  end

  tx_state_t              state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic                   tx_q, tx_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic w_baud_clr;
  logic w_baud_tick;
  logic w_baud_pre_tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_baud_clr),
    .tick     (w_baud_tick),
    .pre_tick (w_baud_pre_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    rd_en_d   = 1'b0;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end
      end
      FETCH: begin
        // Data is valid RD_LATENCY cycles after the cycle the pulse is visible.
        if (lat_q == C_LAT_LAST) begin
          shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
          state_d = START;
        end
      end
      START: begin
        if (w_baud_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == C_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_baud_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Registered pulse: armed one cycle early so it lands on the last stop cycle.
        tx_done_d = w_baud_pre_tick;
        if (w_baud_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    lat_d      = ((state_q == FETCH) && (state_d == FETCH)) ? lat_q + LAT_W'(1) : '0;
    w_baud_clr = (state_d != state_q) || ((state_q == DATA) && w_baud_tick);
    busy_d     = (state_d != IDLE);

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      lat_q     <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      lat_q     <= lat_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;

endmodule
`default_nettype wire
